rgb_breathe_pwm: RTL

// Multi-channel LED "breathing" controller: ramps one channel's PWM duty
// 0->max->0 as a triangle, then hands off to the next channel round-robin.

---
 rtl/rgb_breathe_pwm.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rgb_breathe_pwm.sv
// Round-robin LED breathing controller: one channel at a time ramps its PWM duty 0->max->0.
// Optional gamma correction is enabled by defining GAMMA_EN.
module rgb_breathe_pwm #(
  parameter int CHANNELS   = 3,
  parameter int BITS       = 8,
  parameter int PRESCALER  = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  output logic [CHANNELS-1:0]         pwm_out,
  output logic [$clog2(CHANNELS)-1:0] active_ch,
  output logic [BITS-1:0]             level,
  output logic                        cycle_done
);

  localparam int CH_W = $clog2(CHANNELS);
  localparam logic [BITS-1:0] MAX_LVL = '1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);
  localparam logic [CHANNELS-1:0] OFF_VEC = {CHANNELS{ACTIVE_LOW}};

  typedef enum logic {ST_UP, ST_DOWN} state_t;

  logic [BITS-1:0]     r_pwm_cnt;
  logic [BITS-1:0]     r_level;
  logic [CH_W-1:0]     r_active_ch;
  logic                r_cycle_done;
  logic [CHANNELS-1:0] r_pwm_out;
  state_t              r_state;

  logic                w_period_end;
  logic                w_step;
  logic [BITS-1:0]     w_duty;
  logic [CHANNELS-1:0] w_pwm_next;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_cnt <= '0;
    end else if (en) begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  assign w_period_end = en && (r_pwm_cnt == MAX_LVL);

  generate
    if (PRESCALER > 0) begin : g_pre
      logic [PRESCALER-1:0] r_pre_cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_pre_cnt <= '0;
        end else if (w_period_end) begin
          r_pre_cnt <= r_pre_cnt + 1'b1;
        end
      end

      assign w_step = w_period_end && (&r_pre_cnt);
    end else begin : g_no_pre
      assign w_step = w_period_end;
    end
  endgenerate

  // Triangle ramp; the DOWN->UP turn at level 0 is the channel handoff point.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_UP;
      r_level      <= '0;
      r_active_ch  <= '0;
      r_cycle_done <= 1'b0;
    end else begin
      r_cycle_done <= 1'b0;
      if (w_step) begin
        case (r_state)
          ST_UP: begin
            if (r_level == MAX_LVL) begin
              r_state <= ST_DOWN;
              r_level <= MAX_LVL - 1'b1;
            end else begin
              r_level <= r_level + 1'b1;
            end
          end
          ST_DOWN: begin
            if (r_level != '0) begin
              r_level <= r_level - 1'b1;
            end else begin
              r_state <= ST_UP;
              if (r_active_ch == LAST_CH) begin
                r_active_ch  <= '0;
                r_cycle_done <= 1'b1;
              end else begin
                r_active_ch <= r_active_ch + 1'b1;
              end
            end
          end
          default: r_state <= ST_UP;
        endcase
      end
    end
  end

`ifdef GAMMA_EN
  localparam int PW = 2 * BITS;
  logic [BITS-1:0] r_duty;

  // Squared level keeps only the top BITS of the full-width product.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty <= '0;
    end else begin
      r_duty <= BITS'((PW'(r_level) * PW'(r_level)) >> BITS);
    end
  end

  assign w_duty = r_duty;
`else
  assign w_duty = r_level;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_pwm_next = OFF_VEC;
    if (en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (CH_W'(i) == r_active_ch) begin
          w_pwm_next[i] = ACTIVE_LOW ^ (r_pwm_cnt < w_duty);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_out <= OFF_VEC;
    end else begin
      r_pwm_out <= w_pwm_next;
    end
  end

  assign pwm_out    = r_pwm_out;
  assign active_ch  = r_active_ch;
  assign level      = r_level;
  assign cycle_done = r_cycle_done;

endmodule
